// File: rtl/apb_gpio_cmd_master.sv
// apb_gpio_cmd_master: queued command stream to APB3 initiator with one response per command.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_gpio_cmd_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]               cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic                      busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + APB_ADDR_WIDTH + 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t                    state_q;
  logic [EW-1:0]             mem_q [FIFO_DEPTH];
  logic [AW:0]               wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [31:0]               pwdata_q, rsp_rdata_q;
  logic                      pwrite_q, psel_q, penable_q, rsp_valid_q, rsp_err_q;
  logic                      empty, full, push, pop, timeout;
  logic [EW-1:0]             head;
  assign empty     = wr_ptr_q == rd_ptr_q;
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push      = cmd_valid && !full;
  assign pop       = !empty && (state_q == IDLE || (state_q == RESP && rsp_ready));
  assign wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign cmd_ready = !full;
  assign busy      = !empty || state_q != IDLE;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  assign timeout = !PREADY && to_cnt_q == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) to_cnt_q <= '0;
    else if (state_q == SETUP) to_cnt_q <= '0;
    else if (state_q == ACCESS && !PREADY) to_cnt_q <= to_cnt_q + 16'd1;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge HCLK)
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (pop) {pwrite_q, paddr_q, pwdata_q} <= head;
      case (state_q)
        IDLE: if (pop) begin
          psel_q    <= 1'b1;
          penable_q <= 1'b0;
          state_q   <= SETUP;
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: if (PREADY || timeout) begin
          rsp_rdata_q <= (PREADY && !pwrite_q) ? PRDATA : 32'd0;
          rsp_err_q   <= PREADY ? PSLVERR : 1'b1;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          psel_q      <= pop;
          state_q     <= pop ? SETUP : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_gpio_cmd_master.sv
// tb_apb_gpio_cmd_master: directed vectors for the APB command master, one task per scenario.
module tb_apb_gpio_cmd_master;
  logic        HCLK, HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA, prdata_v;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR, busy, addr_data;
  int vectors = 0;
  int miscompares = 0;

  assign PRDATA = addr_data ? {20'hC0DE0, PADDR} : prdata_v;

  apb_gpio_cmd_master #(.APB_ADDR_WIDTH(12), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .busy(busy)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic push(input logic w, input logic [11:0] a, input logic [31:0] d);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, busy, cmd_ready} !== 7'b0000001) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0000001", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, busy, cmd_ready});
    end
    vectors++;
    if ({PADDR, PWDATA, rsp_rdata} !== 76'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h %h want 0", PADDR, PWDATA, rsp_rdata);
    end
    #2 HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    rsp_ready = 1'b0;
    PREADY    = 1'b1;
    prdata_v  = 32'hDEAD_BEEF;
    push(1'b1, 12'h038, 32'h0100_0005);
    vectors++;
    if ({PSEL, PENABLE} !== 2'b00) begin
      miscompares++;
      $display("FAIL wr_n0: got psel/pen %b want 00", {PSEL, PENABLE});
    end
    tick();
    vectors++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 12'h038, 32'h0100_0005}) begin
      miscompares++;
      $display("FAIL wr_setup: got %b %h %h want 101 038 01000005", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    tick();
    vectors++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
      miscompares++;
      $display("FAIL wr_access: got %b want 110", {PSEL, PENABLE, rsp_valid});
    end
    tick();
    vectors++;
    if ({PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata} !== {4'b0010, 32'd0}) begin
      miscompares++;
      $display("FAIL wr_resp: got %b %h want 0010 00000000", {PSEL, PENABLE, rsp_valid, rsp_err}, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++;
    if ({rsp_valid, busy, PADDR} !== {2'b00, 12'h038}) begin
      miscompares++;
      $display("FAIL wr_done: got %b %h want 00 038", {rsp_valid, busy}, PADDR);
    end
  endtask

  task automatic test_read_wait();
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    prdata_v  = 32'h0100_1105;
    push(1'b0, 12'h034, 32'h0);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid, PADDR} !== {4'b1100, 12'h034}) begin
        miscompares++;
        $display("FAIL rd_wait%0d: got %b %h want 1100 034", i, {PSEL, PENABLE, PWRITE, rsp_valid}, PADDR);
      end
      tick();
    end
    vectors++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
      miscompares++;
      $display("FAIL rd_wait3: got %b want 110", {PSEL, PENABLE, rsp_valid});
    end
    PREADY = 1'b1;
    tick();
    vectors++;
    if ({PENABLE, rsp_valid, rsp_err, rsp_rdata} !== {3'b010, 32'h0100_1105}) begin
      miscompares++;
      $display("FAIL rd_resp: got %b %h want 010 01001105", {PENABLE, rsp_valid, rsp_err}, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] a [5];
    logic [31:0] e [5];
    logic [4:0]  wr;
    wr        = 5'b00100;
    addr_data = 1'b1;
    rsp_ready = 1'b0;
    PREADY    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a[k] = 12'h100 + 12'(k * 4);
      e[k] = wr[k] ? 32'd0 : {20'hC0DE0, a[k]};
      vectors++;
      if (cmd_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_ready%0d: got %b want 1", k, cmd_ready);
      end
      push(wr[k], a[k], 32'h5000_0000 + 32'(k));
    end
    vectors++;
    if ({cmd_ready, PSEL, PENABLE, busy} !== 4'b0001) begin
      miscompares++;
      $display("FAIL fill_full: got %b want 0001", {cmd_ready, PSEL, PENABLE, busy});
    end
    push(1'b0, 12'h3FC, 32'h0);
    tick();
    vectors++;
    if ({cmd_ready, PSEL, rsp_valid, rsp_rdata} !== {3'b001, e[0]}) begin
      miscompares++;
      $display("FAIL fill_hold: got %b %h want 001 %h", {cmd_ready, PSEL, rsp_valid}, rsp_rdata, e[0]);
    end
    rsp_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      vectors++;
      if ({rsp_valid, PSEL, PENABLE, PADDR} !== {3'b010, a[k]}) begin
        miscompares++;
        $display("FAIL drain_setup%0d: got %b %h want 010 %h", k, {rsp_valid, PSEL, PENABLE}, PADDR, a[k]);
      end
      tick();
      tick();
      vectors++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, e[k]}) begin
        miscompares++;
        $display("FAIL drain_rsp%0d: got %b %h want 10 %h", k, {rsp_valid, rsp_err}, rsp_rdata, e[k]);
      end
    end
    tick();
    vectors++;
    if ({rsp_valid, PSEL, busy, cmd_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL drain_end: got %b want 0001", {rsp_valid, PSEL, busy, cmd_ready});
    end
    rsp_ready = 1'b0;
    addr_data = 1'b0;
  endtask

  task automatic test_slverr();
    rsp_ready = 1'b1;
    PREADY    = 1'b1;
    PSLVERR   = 1'b1;
    prdata_v  = 32'h1234_5678;
    push(1'b0, 12'h010, 32'h0);
    repeat (3) tick();
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL slverr_rsp: got %b %h want 11 12345678", {rsp_valid, rsp_err}, rsp_rdata);
    end
    tick();
    PSLVERR = 1'b0;
    push(1'b1, 12'h020, 32'hCAFE_0001);
    repeat (3) tick();
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'd0}) begin
      miscompares++;
      $display("FAIL slverr_next: got %b %h want 10 00000000", {rsp_valid, rsp_err}, rsp_rdata);
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    rsp_ready = 1'b1;
    PREADY    = 1'b0;
    prdata_v  = 32'h0000_0AAA;
    push(1'b0, 12'h044, 32'h0);
    tick();
    tick();
`ifdef APB_MASTER_TIMEOUT_EN
    repeat (7) tick();
    vectors++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
      miscompares++;
      $display("FAIL to_wait7: got %b want 110", {PSEL, PENABLE, rsp_valid});
    end
    tick();
    vectors++;
    if ({PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata} !== {4'b0011, 32'd0}) begin
      miscompares++;
      $display("FAIL to_fire: got %b %h want 0011 00000000", {PSEL, PENABLE, rsp_valid, rsp_err}, rsp_rdata);
    end
    tick();
    PREADY = 1'b1;
`else
    repeat (1000) tick();
    vectors++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
      miscompares++;
      $display("FAIL to_hold: got %b want 110", {PSEL, PENABLE, rsp_valid});
    end
    PREADY = 1'b1;
    tick();
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0000_0AAA}) begin
      miscompares++;
      $display("FAIL to_late: got %b %h want 10 00000aaa", {rsp_valid, rsp_err}, rsp_rdata);
    end
    tick();
`endif
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    push(1'b1, 12'h200, 32'h1);
    push(1'b1, 12'h204, 32'h2);
    push(1'b1, 12'h208, 32'h3);
    vectors++;
    if ({PSEL, PENABLE, busy} !== 3'b111) begin
      miscompares++;
      $display("FAIL rst_pre: got %b want 111", {PSEL, PENABLE, busy});
    end
    #2 HRESETn = 1'b0;
    #1;
    vectors++;
    if ({PSEL, PENABLE, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL rst_async: got %b want 00001", {PSEL, PENABLE, rsp_valid, busy, cmd_ready});
    end
    #2 HRESETn = 1'b1;
    PREADY = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) begin
      tick();
      vectors++;
      if ({PSEL, rsp_valid, busy, cmd_ready} !== 4'b0001) begin
        miscompares++;
        $display("FAIL rst_after: got %b want 0001", {PSEL, rsp_valid, busy, cmd_ready});
      end
    end
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;
    prdata_v  = '0;
    addr_data = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_slverr();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/apb_gpio_cmd_master.md
# apb_gpio_cmd_master

APB initiator that turns a queued stream of register commands into APB3 transfers toward `apb_gpiov2` or any other APB3 responder on the peripheral bus. A CPU-side or sequencer-side producer pushes write and read commands through a valid/ready port. The block buffers them in a small FIFO, runs the SETUP/ACCESS protocol with PREADY wait states, and returns one response per command on a second valid/ready port.

## Interface
- `APB_ADDR_WIDTH`, 12, width of `cmd_addr`/`PADDR`
- `FIFO_DEPTH`, 4, command FIFO entries; power of two, ≥2
- `TIMEOUT_CYCLES`, 255, maximum ACCESS wait cycles with PREADY low; only used with the timeout macro; range 1..65535
- Clock and reset: HCLK is the clock; HRESETn is the reset, asynchronous, active-low.
- `HCLK`  in  1  clock
- `HRESETn`  in  1  async active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  FIFO not full
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  APB_ADDR_WIDTH  target address
- `cmd_wdata`  in  32  write data
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumed
- `rsp_rdata`  out  32  read data; 0 for writes
- `rsp_err`  out  1  PSLVERR, or timeout when enabled
- `PADDR`  out  APB_ADDR_WIDTH; `PWDATA`  out  32; `PWRITE`  out  1; `PSEL`  out  1; `PENABLE`  out  1  APB request
- `PRDATA`  in  32; `PREADY`  in  1; `PSLVERR`  in  1  APB completion
- `busy`  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Command FIFO:
  - Push on `cmd_valid & cmd_ready`.
  - `cmd_ready = !full` is combinational, with no bypass when full.
  - Full and empty are tracked with wrap-bit pointers of width log2(FIFO_DEPTH)+1.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head and register PADDR/PWDATA/PWRITE.
  - Set PSEL=1 and PENABLE=0, then go to SETUP.
- SETUP: set PENABLE=1, then go to ACCESS.
- ACCESS:
  - Hold all request signals while PREADY=0.
  - When PREADY=1:
    - Capture `rsp_rdata` (PRDATA for a read, 0 for a write) and `rsp_err`=PSLVERR.
    - Drop PSEL and PENABLE, set rsp_valid=1, go to RESP.
- RESP:
  - Hold rsp_* until `rsp_ready`.
  - On the handshake, clear rsp_valid. Go to SETUP directly, popping the next entry, if the FIFO is non-empty; otherwise go to IDLE.
- PADDR/PWDATA/PWRITE stay stable from SETUP through the completing ACCESS cycle. Between transfers they keep their last values.
- One transfer is outstanding at a time. Responses return in command order.
- Reset values: PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. After reset the FIFO is empty and cmd_ready=1.

## Timing
- Command accepted at edge N with FIFO empty and FSM IDLE:
  - PSEL=1 after edge N+1.
  - PENABLE=1 after edge N+2.
  - With PREADY=1 in that cycle, rsp_valid=1 after edge N+3.
- Each PREADY-low cycle adds one cycle of latency.
- Back-to-back: if rsp_ready is held high and the FIFO is non-empty, a new SETUP starts the cycle after the response handshake, giving 3 cycles per transfer.
- Push during a full cycle is refused. A pop and a push on the same edge are both honoured.
- HRESETn asserted mid-transfer:
  - PSEL, PENABLE and rsp_valid drop asynchronously.
  - The FIFO is flushed and the in-flight command is lost with no response.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES while PREADY=0, drop PSEL/PENABLE, respond with rsp_err=1 and rsp_rdata=0, and go to RESP.
  - PREADY=1 in the same cycle takes priority and completes normally.
- Not defined: no counter; ACCESS waits indefinitely for PREADY.

## Test plan
- Write 0x038 data 0x0100_0005 with PREADY=1 → PSEL after N+1, PENABLE after N+2, PWRITE=1, rsp_valid after N+3, rsp_err=0, rsp_rdata=0.
- Read 0x034 with PRDATA=0x0100_1105 and 3 PREADY-low cycles → PENABLE held 4 cycles, rsp_rdata=0x0100_1105.
- Push 5 commands with rsp_ready=0 and FIFO_DEPTH=4 → cmd_ready=0 after 4 are queued plus 1 in flight, no APB activity after the first ACCESS. Releasing rsp_ready drains all 5 in order, 3 cycles each.
- Read with PSLVERR=1 and PREADY=1 → rsp_err=1; the next command proceeds normally.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8 and PREADY stuck at 0 → PSEL drops after 8 wait cycles, rsp_err=1. Without the macro, PSEL is still high after 1000 cycles.
- HRESETn pulsed during ACCESS with 2 entries queued → PSEL=0 immediately, busy=0 and cmd_ready=1 after release, no rsp_valid.
